// File: rtl/fft_sample_buffer_if.sv
// Host, engine and swap-control bundle of the ping-pong FFT sample buffer.
// The buffer connects through the slave modport; the driving side uses master.
interface fft_sample_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    host_req_i;
    logic                    host_we_i;
    logic [ADDR_WIDTH-1:0]   host_addr_i;
    logic [DATA_WIDTH-1:0]   host_wdata_i;
    logic [DATA_WIDTH/8-1:0] host_be_i;
    logic                    host_gnt_o;
    logic                    host_rvalid_o;
    logic [DATA_WIDTH-1:0]   host_rdata_o;

    logic                    eng_req_i;
    logic                    eng_we_i;
    logic [ADDR_WIDTH-1:0]   eng_addr_i;
    logic [DATA_WIDTH-1:0]   eng_wdata_i;
    logic                    eng_rvalid_o;
    logic [DATA_WIDTH-1:0]   eng_rdata_o;

    logic                    swap_req_i;
    logic                    swap_ack_o;
    logic                    bank_sel_o;
    logic [ADDR_WIDTH:0]     host_wr_count_o;
    logic                    parity_err_o;

    modport master (
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o,
        output eng_req_i, eng_we_i, eng_addr_i, eng_wdata_i,
        input  eng_rvalid_o, eng_rdata_o,
        output swap_req_i,
        input  swap_ack_o, bank_sel_o, host_wr_count_o, parity_err_o
    );

    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_be_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o,
        input  eng_req_i, eng_we_i, eng_addr_i, eng_wdata_i,
        output eng_rvalid_o, eng_rdata_o,
        input  swap_req_i,
        output swap_ack_o, bank_sel_o, host_wr_count_o, parity_err_o
    );
endinterface

// File: rtl/fft_sample_buffer.sv
// Two-bank ping-pong sample buffer: host fills one bank while the FFT engine uses the other.
// Optional per-byte even parity is built when FFT_SAMPLE_BUFFER_PARITY_EN is defined.
module fft_sample_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk_i,
    input  logic                reset_i,
    fft_sample_buffer_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SWAP  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                bank_sel_q, bank_sel_d;
    logic [ADDR_WIDTH:0] wr_count_q, wr_count_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic                eng_rvalid_q, eng_rvalid_d;
    logic                host_rd_bank_q, host_rd_bank_d;
    logic                eng_rd_bank_q, eng_rd_bank_d;

    logic host_gnt, host_wr_gnt, host_rd_gnt, eng_wr, eng_rd;

    assign host_gnt    = bus.host_req_i && (state_q == ST_IDLE) && !reset_i;
    assign host_wr_gnt = host_gnt && bus.host_we_i;
    assign host_rd_gnt = host_gnt && !bus.host_we_i;
    assign eng_wr      = bus.eng_req_i && bus.eng_we_i;
    assign eng_rd      = bus.eng_req_i && !bus.eng_we_i;

    always_comb begin
        state_d        = state_q;
        bank_sel_d     = bank_sel_q;
        wr_count_d     = wr_count_q;
        host_rvalid_d  = host_rd_gnt;
        eng_rvalid_d   = eng_rd;
        host_rd_bank_d = host_rd_gnt ? bank_sel_q : host_rd_bank_q;
        eng_rd_bank_d  = eng_rd ? ~bank_sel_q : eng_rd_bank_q;
        if (host_wr_gnt && (wr_count_q != COUNT_MAX)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
        // Ownership flips on entry to SWAP so bank_sel, ack and the cleared count appear together.
        case (state_q)
            ST_IDLE: begin
                if (bus.swap_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d    = ST_SWAP;
                bank_sel_d = ~bank_sel_q;
                wr_count_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            bank_sel_q     <= 1'b0;
            wr_count_q     <= '0;
            host_rvalid_q  <= 1'b0;
            eng_rvalid_q   <= 1'b0;
            host_rd_bank_q <= 1'b0;
            eng_rd_bank_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bank_sel_q     <= bank_sel_d;
            wr_count_q     <= wr_count_d;
            host_rvalid_q  <= host_rvalid_d;
            eng_rvalid_q   <= eng_rvalid_d;
            host_rd_bank_q <= host_rd_bank_d;
            eng_rd_bank_q  <= eng_rd_bank_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic                  host_owns, we, re;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NB-1:0]         be;
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rdata_q;

        always_comb begin
            host_owns = (bank_sel_q == 1'(gi));
            if (host_owns) begin
                we    = host_wr_gnt;
                re    = host_rd_gnt;
                addr  = bus.host_addr_i;
                wdata = bus.host_wdata_i;
                be    = bus.host_be_i;
            end else begin
                we    = eng_wr;
                re    = eng_rd;
                addr  = bus.eng_addr_i;
                wdata = bus.eng_wdata_i;
                be    = '1;
            end
        end

        always_ff @(posedge clk_i) begin
            for (int b = 0; b < NB; b++) begin
                if (we && be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[addr];
            end
        end

`ifdef FFT_SAMPLE_BUFFER_PARITY_EN
        logic [NB-1:0] par_mem [DEPTH];
        logic [NB-1:0] par_rd_q;
        logic [NB-1:0] par_calc;
        logic          rd_q;
        logic          perr;

        always_ff @(posedge clk_i) begin
            for (int b = 0; b < NB; b++) begin
                if (we && be[b]) begin
                    par_mem[addr][b] <= ^wdata[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                rd_q     <= 1'b0;
                par_rd_q <= '0;
            end else begin
                rd_q <= re;
                if (re) begin
                    par_rd_q <= par_mem[addr];
                end
            end
        end

        always_comb begin
            par_calc = '0;
            for (int b = 0; b < NB; b++) begin
                par_calc[b] = ^rdata_q[8*b +: 8];
            end
        end

        assign perr = rd_q && (par_calc != par_rd_q);
`endif
    end

`ifdef FFT_SAMPLE_BUFFER_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q || g_bank[0].perr || g_bank[1].perr;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err_o = parity_err_q;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.host_gnt_o      = host_gnt;
    assign bus.host_rvalid_o   = host_rvalid_q;
    assign bus.host_rdata_o    = host_rd_bank_q ? g_bank[1].rdata_q : g_bank[0].rdata_q;
    assign bus.eng_rvalid_o    = eng_rvalid_q;
    assign bus.eng_rdata_o     = eng_rd_bank_q ? g_bank[1].rdata_q : g_bank[0].rdata_q;
    assign bus.swap_ack_o      = (state_q == ST_SWAP) && !reset_i;
    assign bus.bank_sel_o      = bank_sel_q;
    assign bus.host_wr_count_o = wr_count_q;
endmodule

// File: tb/tb_fft_sample_buffer.sv
// Self-checking bench for fft_sample_buffer: directed pins plus a randomized run
// compared every cycle against a bank/ownership model kept in plain arrays.
module tb_fft_sample_buffer;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    fft_sample_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fft_sample_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: memory contents per bank, which bank the host owns,
    // and how many cycles remain until a requested swap lands.
    logic [DW-1:0] mdl_mem [2][DEPTH];
    int            own        = 0;
    int            swap_phase = 0;   // 0 none pending, 1 waiting one cycle, 2 swap cycle
    int            count      = 0;
    bit            hrv        = 0;
    bit            erv        = 0;
    logic [DW-1:0] hrd        = '0;
    logic [DW-1:0] erd        = '0;
    bit            chk_en     = 0;

    always @(negedge clk_i) begin
        if (chk_en) begin
            bit gnt_exp;
            gnt_exp = !reset_i && swap_phase == 0 && bus.host_req_i;
            check("host_gnt", bus.host_gnt_o, gnt_exp);
            check("swap_ack", bus.swap_ack_o, !reset_i && swap_phase == 2);
            check("bank_sel", bus.bank_sel_o, own);
            check("wr_count", bus.host_wr_count_o, count);
            check("host_rvalid", bus.host_rvalid_o, hrv);
            if (hrv) check("host_rdata", bus.host_rdata_o, hrd);
            check("eng_rvalid", bus.eng_rvalid_o, erv);
            if (erv) check("eng_rdata", bus.eng_rdata_o, erd);
            check("parity_err", bus.parity_err_o, 0);

            if (reset_i) begin
                own = 0; swap_phase = 0; count = 0; hrv = 0; erv = 0;
            end else begin
                hrv = 0;
                erv = 0;
                if (gnt_exp) begin
                    if (bus.host_we_i) begin
                        for (int b = 0; b < NB; b++)
                            if (bus.host_be_i[b])
                                mdl_mem[own][bus.host_addr_i][8*b +: 8] = bus.host_wdata_i[8*b +: 8];
                        if (count < DEPTH) count++;
                    end else begin
                        hrv = 1;
                        hrd = mdl_mem[own][bus.host_addr_i];
                    end
                end
                if (bus.eng_req_i) begin
                    if (bus.eng_we_i) begin
                        mdl_mem[1-own][bus.eng_addr_i] = bus.eng_wdata_i;
                    end else begin
                        erv = 1;
                        erd = mdl_mem[1-own][bus.eng_addr_i];
                    end
                end
                if (swap_phase == 0) begin
                    if (bus.swap_req_i) swap_phase = 1;
                end else if (swap_phase == 1) begin
                    swap_phase = 2;
                    own        = 1 - own;
                    count      = 0;
                end else begin
                    swap_phase = 0;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.host_req_i   = 1'b0;
        bus.host_we_i    = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        bus.host_be_i    = '0;
        bus.eng_req_i    = 1'b0;
        bus.eng_we_i     = 1'b0;
        bus.eng_addr_i   = '0;
        bus.eng_wdata_i  = '0;
        bus.swap_req_i   = 1'b0;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        bus.host_req_i   = 1'b1;
        bus.host_we_i    = 1'b1;
        bus.host_addr_i  = a;
        bus.host_wdata_i = d;
        bus.host_be_i    = be;
    endtask

    task automatic host_rd(input logic [AW-1:0] a);
        bus.host_req_i  = 1'b1;
        bus.host_we_i   = 1'b0;
        bus.host_addr_i = a;
        bus.host_be_i   = '0;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        step(2);
        chk_en = 1;
        host_rd(0);
        #1 check("gnt_in_reset", bus.host_gnt_o, 0);
        idle();
        reset_i = 1'b0;
        check("rst_bank_sel", bus.bank_sel_o, 0);
        check("rst_count", bus.host_wr_count_o, 0);
        check("rst_host_rdata", bus.host_rdata_o, 0);
        check("rst_eng_rdata", bus.eng_rdata_o, 0);
        check("rst_parity", bus.parity_err_o, 0);

        // Basic write then read-back with single-cycle latency
        host_wr(10'h000, 32'hA5A5A5A5, 4'hF);
        step();
        host_rd(10'h000);
        #1 check("rd_gnt", bus.host_gnt_o, 1);
        step();
        check("rd_rvalid", bus.host_rvalid_o, 1);
        check("rd_data", bus.host_rdata_o, 32'hA5A5A5A5);
        check("rd_count", bus.host_wr_count_o, 1);
        idle();
        step();
        check("rvalid_pulse", bus.host_rvalid_o, 0);

        // Byte-enable merge
        host_wr(10'h001, 32'h12345678, 4'hF);
        step();
        host_wr(10'h001, 32'hFFFFFFFF, 4'h2);
        step();
        host_rd(10'h001);
        step();
        check("be_merge", bus.host_rdata_o, 32'h1234FF78);
        idle();

        // Swap hands the host bank over to the engine
        host_wr(10'h010, 32'hDEADBEEF, 4'hF);
        step();
        idle();
        bus.swap_req_i = 1'b1;
        step();
        bus.swap_req_i = 1'b0;
        check("ack_drain", bus.swap_ack_o, 0);
        step();
        check("ack_swap", bus.swap_ack_o, 1);
        check("sel_swap", bus.bank_sel_o, 1);
        check("cnt_swap", bus.host_wr_count_o, 0);
        step();
        check("ack_after", bus.swap_ack_o, 0);
        bus.eng_req_i  = 1'b1;
        bus.eng_we_i   = 1'b0;
        bus.eng_addr_i = 10'h010;
        step();
        check("eng_rvalid", bus.eng_rvalid_o, 1);
        check("eng_rdata", bus.eng_rdata_o, 32'hDEADBEEF);
        idle();

        // Swap request coincident with a granted host read
        host_wr(10'h000, 32'h0BADF00D, 4'hF);
        step();
        host_rd(10'h000);
        bus.swap_req_i = 1'b1;
        #1 check("co_gnt", bus.host_gnt_o, 1);
        step();
        bus.swap_req_i = 1'b0;
        check("co_rvalid", bus.host_rvalid_o, 1);
        check("co_rdata", bus.host_rdata_o, 32'h0BADF00D);
        #1 check("co_gnt_drain", bus.host_gnt_o, 0);
        step();
        check("co_gnt_swap", bus.host_gnt_o, 0);
        check("co_ack", bus.swap_ack_o, 1);
        check("co_sel", bus.bank_sel_o, 0);
        step();
        check("co_gnt_back", bus.host_gnt_o, 1);
        idle();
        step();

        // Reset during DRAIN aborts the swap
        bus.swap_req_i = 1'b1;
        step();
        bus.swap_req_i = 1'b0;
        reset_i = 1'b1;
        host_rd(10'h000);
        #1 check("abort_gnt_rst", bus.host_gnt_o, 0);
        step();
        reset_i = 1'b0;
        check("abort_sel", bus.bank_sel_o, 0);
        check("abort_ack", bus.swap_ack_o, 0);
        #1 check("abort_gnt_back", bus.host_gnt_o, 1);
        idle();
        step(2);
        check("abort_no_ack", bus.swap_ack_o, 0);
        check("abort_sel2", bus.bank_sel_o, 0);

        // Seed addresses 0..31 of both banks, then random traffic
        for (int a = 0; a < 32; a++) begin
            host_wr(AW'(a), $urandom, 4'hF);
            bus.eng_req_i   = 1'b1;
            bus.eng_we_i    = 1'b1;
            bus.eng_addr_i  = AW'(a);
            bus.eng_wdata_i = $urandom;
            step();
        end
        for (int i = 0; i < 3000; i++) begin
            bus.host_req_i   = ($urandom_range(0, 3) != 0);
            bus.host_we_i    = $urandom_range(0, 1);
            bus.host_addr_i  = AW'($urandom_range(0, 31));
            bus.host_wdata_i = $urandom;
            bus.host_be_i    = NB'($urandom_range(0, 15));
            bus.eng_req_i    = ($urandom_range(0, 2) != 0);
            bus.eng_we_i     = $urandom_range(0, 1);
            bus.eng_addr_i   = AW'($urandom_range(0, 31));
            bus.eng_wdata_i  = $urandom;
            bus.swap_req_i   = ($urandom_range(0, 15) == 0);
            reset_i          = ($urandom_range(0, 199) == 0);
            if (reset_i) bus.eng_req_i = 1'b0;
            step();
        end
        idle();
        reset_i = 1'b0;
        step(2);

`ifdef FFT_SAMPLE_BUFFER_PARITY_EN
        chk_en  = 0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        host_wr(10'h005, 32'h01020304, 4'hF);
        step();
        idle();
        dut.g_bank[0].par_mem[5] = dut.g_bank[0].par_mem[5] ^ 4'b0001;
        host_rd(10'h005);
        step();
        check("par_rdata", bus.host_rdata_o, 32'h01020304);
        idle();
        step();
        check("par_err_set", bus.parity_err_o, 1);
        step(3);
        check("par_err_sticky", bus.parity_err_o, 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("par_err_clr", bus.parity_err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
